uart_tx_streamer: RTL
=====================

Name: uart_tx_streamer

Overview:
- Transmit-side counterpart to the plotter's UART receive path.
- On a start request, it reads a newline-terminated byte string out of data memory, one byte per 32-bit word in bits [7:0].
- Each byte is serialized onto the tx line as 8N1 UART.
- Used to echo status and acknowledgements back to the host PC after a command block has been processed.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200 baud); must be >= 2.
- ADDR_W, 12, data memory word address width.
- MAX_LEN, 4095, maximum number of bytes sent per request; a safety stop when no newline is found.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- resetn  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin streaming; sampled only in IDLE.
- base_addr  input  ADDR_W  word address of the first byte; latched on an accepted start.
- mem_rden  output  1  memory read strobe, asserted for one cycle per fetch.
- mem_addr  output  ADDR_W  memory word address; valid while mem_rden is high.
- mem_q  input  32  memory read data; valid exactly one clk cycle after mem_rden; only [7:0] is used.
- tx  output  1  UART serial output; idle level is high.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse when the stream completes.
- count  output  ADDR_W  bytes fully transmitted in the current or last stream.

Behaviour:
- Reset (asynchronous, resetn=0):
  - tx=1, busy=0, done=0, mem_rden=0, mem_addr=0, count=0.
  - FSM goes to IDLE and the baud counter clears.
  - Asserting reset mid-frame forces tx high immediately; there is no partial-frame completion.
- FSM states: IDLE, FETCH, WAIT, START, DATA, STOP, NEXT, FINISH.
- IDLE:
  - tx=1, busy=0.
  - start=1 moves to FETCH: latches ptr<=base_addr, clears count to 0, sets busy=1 on the next cycle.
- FETCH: mem_rden=1, mem_addr=ptr, for one cycle; then WAIT.
- WAIT: latches shreg<=mem_q[7:0] at the end of this cycle; then START.
- START:
  - tx=0 for CLKS_PER_BIT cycles.
  - Baud counter counts 0..CLKS_PER_BIT-1, then goes to DATA with bit index 0.
- DATA:
  - tx=shreg[bit], LSB first, each bit held CLKS_PER_BIT cycles.
  - After bit 7 completes, go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - On completion count<=count+1, then go to NEXT.
- NEXT (single cycle):
  - If the sent byte==8'd10 (LF) or count==MAX_LEN, go to FINISH.
  - Otherwise ptr<=ptr+1 (wraps modulo 2^ADDR_W, 4095->0) and go to FETCH.
- FINISH: done=1 for exactly one cycle, busy=0 in the same cycle, then IDLE.
- Frame timing:
  - One frame is exactly 10*CLKS_PER_BIT cycles of tx activity.
  - Inter-frame gap is exactly 3 cycles of tx=1 (NEXT, FETCH, WAIT) on top of the stop bit.
- Latency: accepted start to tx falling edge is 3 cycles (FETCH, WAIT, START entry).
- start while busy=1 is ignored: no restart, no queueing.
- start in the same cycle as FINISH is ignored; start must come from IDLE.
- Byte values 0x00 and 0x0B carry no special meaning and are transmitted normally; only 0x0A terminates.
- Bits [31:8] of mem_q are ignored.
- count holds its final value after done until the next accepted start.
- mem_addr holds its last value when mem_rden=0.

Test Plan (CLKS_PER_BIT=4, MAX_LEN=4095 unless stated):
- Memory words 0x10..0x12 = 'H','I',0x0A; pulse start with base_addr=0x10 -> three frames decode as 0x48,0x49,0x0A LSB first, each 40 cycles long; done pulses once; count=3; busy low after done.
- Single byte 0x0A at base_addr 0x000 -> tx low exactly 3 cycles after start; one frame; done; count=1; mem_addr reads only 0x000.
- Wrap: base_addr=0xFFF holding 0x41, address 0x000 holding 0x0A -> fetch addresses 0xFFF then 0x000; two frames; count=2.
- MAX_LEN=2, memory holds 0x31,0x32,0x33 with no LF -> exactly two frames (0x31,0x32); done; count=2; no fetch of the third address.
- start re-pulsed during the DATA state of frame 1 -> ignored: byte sequence and count are unchanged versus a single start.
- resetn pulsed low during the DATA state -> tx=1, busy=0, count=0 within the same cycle; a new start afterwards streams correctly from base_addr.

Source files
------------

// File: rtl/uart_tx_streamer.sv
// -----------------------------------------------------------------------------
// uart_tx_streamer
//
// Streams a newline-terminated byte string out of word-addressed data memory
// and serializes each byte onto a UART tx line as 8N1, LSB first. Each memory
// word carries one byte in bits [7:0]. Streaming stops after the LF (0x0A)
// byte has been sent, or after MAX_LEN bytes when no LF is found.
//
// Ports:
//   clk        in   1       system clock, rising-edge
//   resetn     in   1       asynchronous active-low reset
//   start      in   1       request to begin streaming, honoured only when idle
//   base_addr  in   ADDR_W  word address of the first byte
//   mem_rden   out  1       one-cycle memory read strobe per byte fetch
//   mem_addr   out  ADDR_W  word address being fetched, held between fetches
//   mem_q      in   32      read data, valid one cycle after mem_rden
//   tx         out  1       UART serial output, idles high
//   busy       out  1       high from accepted start until the done pulse
//   done       out  1       one-cycle completion pulse
//   count      out  ADDR_W  bytes fully sent in the current or last stream
// -----------------------------------------------------------------------------
module uart_tx_streamer #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 12,
    parameter int MAX_LEN      = 4095
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              mem_rden,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_q,
    output logic              tx,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] count
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]     BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W-1:0] MAX_LEN_C = ADDR_W'(MAX_LEN);
    localparam logic [7:0]        LF_BYTE   = 8'h0A;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_WAIT   = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
        S_STOP   = 3'd5,
        S_NEXT   = 3'd6,
        S_FINISH = 3'd7
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shreg_q, shreg_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              mem_rden_q, mem_rden_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              baud_last_s;

    // Only the low byte of each memory word carries payload.
    logic unused_mem_hi_s;
    assign unused_mem_hi_s = ^mem_q[31:8];

    assign baud_last_s = (baud_q == BAUD_LAST);

    // Next-state logic for the sequencer, baud timing, pointer and byte count.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    ptr_d   = base_addr;
                    count_d = {ADDR_W{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Read data arrives this cycle; the start bit begins next.
                shreg_d = mem_q[7:0];
                baud_d  = {CW{1'b0}};
                state_d = S_START;
            end
            S_START: begin
                if (baud_last_s) begin
                    baud_d  = {CW{1'b0}};
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            S_DATA: begin
                if (baud_last_s) begin
                    baud_d = {CW{1'b0}};
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            S_STOP: begin
                if (baud_last_s) begin
                    baud_d  = {CW{1'b0}};
                    count_d = count_q + ADDR_W'(1);
                    state_d = S_NEXT;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            S_NEXT: begin
                // count already includes the byte just sent.
                if ((shreg_q == LF_BYTE) || (count_q == MAX_LEN_C)) begin
                    state_d = S_FINISH;
                end else begin
                    ptr_d   = ptr_q + ADDR_W'(1);
                    state_d = S_FETCH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state so the
    // outputs are registered yet aligned with the state they describe.
    always_comb begin
        mem_rden_d = (state_d == S_FETCH);
        done_d     = (state_d == S_FINISH);
        busy_d     = (state_d != S_IDLE) && (state_d != S_FINISH);
        if (state_d == S_FETCH) begin
            mem_addr_d = ptr_d;
        end else begin
            mem_addr_d = mem_addr_q;
        end
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shreg_d[bit_d];
            default: tx_d = 1'b1;
        endcase
    end

    // State and output registers; reset forces the line idle immediately.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            baud_q     <= {CW{1'b0}};
            bit_q      <= 3'd0;
            shreg_q    <= 8'd0;
            ptr_q      <= {ADDR_W{1'b0}};
            count_q    <= {ADDR_W{1'b0}};
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mem_rden_q <= 1'b0;
            mem_addr_q <= {ADDR_W{1'b0}};
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            ptr_q      <= ptr_d;
            count_q    <= count_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mem_rden_q <= mem_rden_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign count    = count_q;
    assign mem_rden = mem_rden_q;
    assign mem_addr = mem_addr_q;

endmodule
